// File: rtl/mesa_nib_decode.sv
// Mesa-Bus Wi nibble-to-byte decoder: local delivery for slot 00/FF, slot-decremented forwarding otherwise.
// Byte processed two cycles after its low nibble; one-byte Wo holding register, drops and flags overflow while busy.
module mesa_nib_decode (
    input  logic       clk,
    input  logic       reset,
    input  logic       mesa_wi_flush,
    input  logic       mesa_wi_nib_en,
    input  logic [3:0] mesa_wi_nib_d,
    output logic       mesa_wo_byte_en,
    output logic [7:0] mesa_wo_byte_d,
    input  logic       mesa_wo_busy,
    output logic       loc_start,
    output logic [3:0] loc_subslot,
    output logic [3:0] loc_cmd,
    output logic       loc_byte_en,
    output logic [7:0] loc_byte_d,
    output logic       loc_done,
    output logic       pkt_active,
    output logic       wo_overflow
);
    localparam logic [7:0] PREAMBLE = 8'hF0;

    typedef enum logic [2:0] {ST_IDLE, ST_SLOT, ST_HDR, ST_LEN, ST_PAYLOAD} state_t;
    state_t state;

    logic       nib_en_q;
    logic [3:0] nib_d_q;
    logic       nib_phase;
    logic [3:0] nib_hi;
    logic       byte_vld;
    logic [7:0] byte_dat;

    logic       pkt_loc;
    logic       pkt_fwd;
    logic [7:0] hdr_q;
    logic [7:0] cnt;
    logic       loc_done_pend;

    logic       hold_full;
    logic       hold_tent;
    logic       pre_lost;
    logic [7:0] hold_dat;

    logic       byte_go;
    logic       slot_loc;
    logic       slot_fwd;
    logic       pre_load;
    logic       fwd_load;
    logic [7:0] fwd_byte;
    logic       hold_issue;
    logic       hold_accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nib_en_q  <= 1'b0;
            nib_d_q   <= 4'h0;
            nib_phase <= 1'b0;
            nib_hi    <= 4'h0;
            byte_vld  <= 1'b0;
            byte_dat  <= 8'h00;
        end else if (mesa_wi_flush) begin
            nib_en_q  <= 1'b0;
            nib_phase <= 1'b0;
            byte_vld  <= 1'b0;
        end else begin
            nib_en_q <= mesa_wi_nib_en;
            nib_d_q  <= mesa_wi_nib_d;
            byte_vld <= 1'b0;
            if (nib_en_q) begin
                if (!nib_phase) begin
                    nib_hi <= nib_d_q;
                end else begin
                    byte_dat <= {nib_hi, nib_d_q};
                    byte_vld <= 1'b1;
                end
                nib_phase <= ~nib_phase;
            end
        end
    end

    // The preamble is parked tentatively until the slot byte says whether the packet leaves on Wo;
    // a forward slot releases it in the same cycle the decremented slot is loaded behind it.
    always_comb begin
        byte_go  = byte_vld & ~mesa_wi_flush;
        slot_loc = (byte_dat == 8'h00) || (byte_dat == 8'hFF);
        slot_fwd = byte_go && (state == ST_SLOT) && (byte_dat != 8'h00);
        pre_load = byte_go && (state == ST_IDLE) && (byte_dat == PREAMBLE);
        fwd_load = pre_load;
        fwd_byte = PREAMBLE;
        if (slot_fwd) begin
            fwd_load = 1'b1;
            fwd_byte = (byte_dat == 8'hFF) ? 8'hFF : byte_dat - 8'd1;
        end else if (byte_go && pkt_fwd &&
                     (state == ST_HDR || state == ST_LEN || state == ST_PAYLOAD)) begin
            fwd_load = 1'b1;
            fwd_byte = byte_dat;
        end
        hold_issue  = hold_full && !mesa_wo_busy && !mesa_wo_byte_en && (!hold_tent || slot_fwd);
        hold_accept = !hold_full || hold_issue;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mesa_wo_byte_en <= 1'b0;
            mesa_wo_byte_d  <= 8'h00;
            hold_full       <= 1'b0;
            hold_tent       <= 1'b0;
            hold_dat        <= 8'h00;
            pre_lost        <= 1'b0;
            wo_overflow     <= 1'b0;
        end else begin
            mesa_wo_byte_en <= hold_issue;
            if (hold_issue) begin
                mesa_wo_byte_d <= hold_dat;
                hold_full      <= 1'b0;
            end
            if (hold_tent && (mesa_wi_flush || (byte_go && state == ST_SLOT))) begin
                hold_tent <= 1'b0;
                if (!slot_fwd)
                    hold_full <= 1'b0;
            end
            if (fwd_load) begin
                if (hold_accept) begin
                    hold_full <= 1'b1;
                    hold_dat  <= fwd_byte;
                    hold_tent <= pre_load;
                end else if (!pre_load) begin
                    wo_overflow <= 1'b1;
                end
            end
            if (pre_load)
                pre_lost <= !hold_accept;
            if (slot_fwd && pre_lost)
                wo_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            pkt_active    <= 1'b0;
            pkt_loc       <= 1'b0;
            pkt_fwd       <= 1'b0;
            hdr_q         <= 8'h00;
            cnt           <= 8'h00;
            loc_done_pend <= 1'b0;
            loc_start     <= 1'b0;
            loc_subslot   <= 4'h0;
            loc_cmd       <= 4'h0;
            loc_byte_en   <= 1'b0;
            loc_byte_d    <= 8'h00;
            loc_done      <= 1'b0;
        end else begin
            loc_start     <= 1'b0;
            loc_byte_en   <= 1'b0;
            loc_done      <= loc_done_pend;
            loc_done_pend <= 1'b0;
            if (mesa_wi_flush) begin
                state      <= ST_IDLE;
                pkt_active <= 1'b0;
                loc_done   <= 1'b0;
            end else if (byte_vld) begin
                unique case (state)
                    ST_IDLE: begin
                        if (byte_dat == PREAMBLE) begin
                            state      <= ST_SLOT;
                            pkt_active <= 1'b1;
                        end
                    end
                    ST_SLOT: begin
                        pkt_loc <= slot_loc;
                        pkt_fwd <= (byte_dat != 8'h00);
                        state   <= ST_HDR;
                    end
                    ST_HDR: begin
                        hdr_q <= byte_dat;
                        state <= ST_LEN;
                    end
                    ST_LEN: begin
                        cnt <= byte_dat;
                        if (pkt_loc) begin
                            loc_start     <= 1'b1;
                            loc_subslot   <= hdr_q[7:4];
                            loc_cmd       <= hdr_q[3:0];
                            loc_done_pend <= (byte_dat == 8'h00);
                        end
                        if (byte_dat == 8'h00) begin
                            state      <= ST_IDLE;
                            pkt_active <= 1'b0;
                        end else begin
                            state <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        cnt <= cnt - 8'd1;
                        if (pkt_loc) begin
                            loc_byte_en <= 1'b1;
                            loc_byte_d  <= byte_dat;
                        end
                        if (cnt == 8'd1) begin
                            loc_done   <= pkt_loc;
                            state      <= ST_IDLE;
                            pkt_active <= 1'b0;
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        pkt_active <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mesa_nib_decode.sv
// Scoreboard bench for mesa_nib_decode: packet-level model queues expected local events and Wo bytes.
module tb_mesa_nib_decode;
    logic       clk = 1'b0;
    logic       reset;
    logic       mesa_wi_flush;
    logic       mesa_wi_nib_en;
    logic [3:0] mesa_wi_nib_d;
    logic       mesa_wo_byte_en;
    logic [7:0] mesa_wo_byte_d;
    logic       mesa_wo_busy;
    logic       loc_start;
    logic [3:0] loc_subslot;
    logic [3:0] loc_cmd;
    logic       loc_byte_en;
    logic [7:0] loc_byte_d;
    logic       loc_done;
    logic       pkt_active;
    logic       wo_overflow;

    always #5 clk = ~clk;

    mesa_nib_decode dut (
        .clk            (clk),
        .reset          (reset),
        .mesa_wi_flush  (mesa_wi_flush),
        .mesa_wi_nib_en (mesa_wi_nib_en),
        .mesa_wi_nib_d  (mesa_wi_nib_d),
        .mesa_wo_byte_en(mesa_wo_byte_en),
        .mesa_wo_byte_d (mesa_wo_byte_d),
        .mesa_wo_busy   (mesa_wo_busy),
        .loc_start      (loc_start),
        .loc_subslot    (loc_subslot),
        .loc_cmd        (loc_cmd),
        .loc_byte_en    (loc_byte_en),
        .loc_byte_d     (loc_byte_d),
        .loc_done       (loc_done),
        .pkt_active     (pkt_active),
        .wo_overflow    (wo_overflow)
    );

    localparam int K_START = 0;
    localparam int K_BYTE  = 1;
    localparam int K_DONE  = 2;

    typedef struct {
        int         kind;
        logic [7:0] dat;
        bit         zl;
    } loc_ev_t;

    loc_ev_t    loc_q[$];
    logic [7:0] wo_q[$];
    logic [7:0] pl[256];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_start_cyc = 0;
    logic prev_wo_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=none", name, act);
    endtask

    // Monitor: every DUT output event is checked against the head of the matching queue.
    always @(negedge clk) begin
        loc_ev_t ev;
        logic [7:0] wb;
        cyc++;
        if (loc_start) begin
            if (loc_q.size() == 0) fail("unexpected_loc_start", 32'({loc_subslot, loc_cmd}));
            else begin
                ev = loc_q.pop_front();
                chk("start_order", 32'(K_START), 32'(ev.kind));
                chk("start_hdr", 32'({loc_subslot, loc_cmd}), 32'(ev.dat));
            end
            last_start_cyc = cyc;
        end
        if (loc_byte_en) begin
            if (loc_q.size() == 0) fail("unexpected_loc_byte", 32'(loc_byte_d));
            else begin
                ev = loc_q.pop_front();
                chk("byte_order", 32'(K_BYTE), 32'(ev.kind));
                chk("loc_byte_d", 32'(loc_byte_d), 32'(ev.dat));
            end
        end
        if (loc_done) begin
            if (loc_q.size() == 0) fail("unexpected_loc_done", 32'(cyc));
            else begin
                ev = loc_q.pop_front();
                chk("done_order", 32'(K_DONE), 32'(ev.kind));
                if (ev.zl) chk("done_zero_len_timing", 32'(cyc), 32'(last_start_cyc + 1));
                else chk("done_with_last_byte", 32'(loc_byte_en), 32'd1);
            end
        end
        if (mesa_wo_byte_en) begin
            chk("wo_spacing", 32'(prev_wo_en), 32'd0);
            if (wo_q.size() == 0) fail("unexpected_wo_byte", 32'(mesa_wo_byte_d));
            else begin
                wb = wo_q.pop_front();
                chk("wo_byte_d", 32'(mesa_wo_byte_d), 32'(wb));
            end
        end
        prev_wo_en = mesa_wo_byte_en;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_nib(input logic [3:0] n);
        @(negedge clk);
        mesa_wi_nib_en = 1'b1;
        mesa_wi_nib_d  = n;
        @(negedge clk);
        mesa_wi_nib_en = 1'b0;
        idle($urandom_range(0, 2));
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[7:4]);
        send_nib(b[3:0]);
    endtask

    task automatic push_loc(input int kind, input logic [7:0] dat, input bit zl);
        loc_ev_t ev;
        ev.kind = kind;
        ev.dat  = dat;
        ev.zl   = zl;
        loc_q.push_back(ev);
    endtask

    // Reference: slot 00 local, FF local+forward, others forward with slot-1; payload from pl[].
    task automatic send_pkt(input logic [7:0] slot, input logic [7:0] hdr, input int n);
        bit is_loc;
        bit is_fwd;
        is_loc = (slot == 8'h00) || (slot == 8'hFF);
        is_fwd = (slot != 8'h00);
        if (is_loc) begin
            push_loc(K_START, hdr, 1'b0);
            for (int i = 0; i < n; i++) push_loc(K_BYTE, pl[i], 1'b0);
            push_loc(K_DONE, 8'h00, n == 0);
        end
        if (is_fwd) begin
            wo_q.push_back(8'hF0);
            wo_q.push_back(slot == 8'hFF ? 8'hFF : slot - 8'd1);
            wo_q.push_back(hdr);
            wo_q.push_back(8'(n));
            for (int i = 0; i < n; i++) wo_q.push_back(pl[i]);
        end
        send_byte(8'hF0);
        send_byte(slot);
        send_byte(hdr);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) send_byte(pl[i]);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        idle(6);
        while ((loc_q.size() != 0 || wo_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (loc_q.size() != 0 || wo_q.size() != 0)
            fail({name, "_drain_timeout"}, 32'(loc_q.size() + wo_q.size()));
        idle(4);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_outs"}, 32'({mesa_wo_byte_en, mesa_wo_byte_d, loc_start, loc_subslot, loc_cmd,
                                  loc_byte_en, loc_byte_d, loc_done, pkt_active, wo_overflow}), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] slot;
        logic [7:0] junk;
        int n;
        reset = 1'b0;
        mesa_wi_flush = 1'b0;
        mesa_wi_nib_en = 1'b0;
        mesa_wi_nib_d = 4'h0;
        mesa_wo_busy = 1'b0;
        idle(3);
        chk_all_zero("reset");
        reset = 1'b1;
        idle(3);

        // Local: F0 00 35 02 AB CD
        pl[0] = 8'hAB; pl[1] = 8'hCD;
        send_pkt(8'h00, 8'h35, 2);
        drain("local");
        // Forward: F0 04 12 01 77
        pl[0] = 8'h77;
        send_pkt(8'h04, 8'h12, 1);
        drain("forward");
        // Broadcast, zero length
        send_pkt(8'hFF, 8'h21, 0);
        drain("broadcast");
        // Maximum length local packet
        for (int i = 0; i < 255; i++) pl[i] = 8'($urandom);
        send_pkt(8'h00, 8'h9C, 255);
        drain("len255");

        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom);
                if (junk == 8'hF0) junk = 8'h0F;
                send_byte(junk);
            end
            case ($urandom_range(0, 3))
                0: slot = 8'h00;
                1: slot = 8'hFF;
                default: slot = 8'($urandom_range(1, 254));
            endcase
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
            send_pkt(slot, 8'($urandom), n);
        end
        drain("random");
        chk("no_overflow_when_idle", 32'(wo_overflow), 32'd0);
        chk("idle_after_random", 32'(pkt_active), 32'd0);

        // Overflow: busy across a forward packet keeps only the preamble
        mesa_wo_busy = 1'b1;
        wo_q.push_back(8'hF0);
        send_byte(8'hF0);
        idle(4);
        chk("ovf_after_preamble", 32'(wo_overflow), 32'd0);
        send_byte(8'h05);
        idle(4);
        chk("ovf_after_slot", 32'(wo_overflow), 32'd1);
        send_byte(8'h12);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(6);
        chk("ovf_held_not_issued", 32'(wo_q.size()), 32'd1);
        mesa_wo_busy = 1'b0;
        drain("overflow");
        chk("ovf_sticky", 32'(wo_overflow), 32'd1);

        // Flush after first of three local payload bytes
        push_loc(K_START, 8'h34, 1'b0);
        push_loc(K_BYTE, 8'h11, 1'b0);
        send_byte(8'hF0);
        send_byte(8'h00);
        send_byte(8'h34);
        send_byte(8'h03);
        send_byte(8'h11);
        idle(4);
        chk("active_before_flush", 32'(pkt_active), 32'd1);
        mesa_wi_flush = 1'b1;
        @(negedge clk);
        mesa_wi_flush = 1'b0;
        chk("active_after_flush", 32'(pkt_active), 32'd0);
        idle(8);
        send_pkt(8'h00, 8'h00, 0);
        drain("after_flush");

        // Reset during the LEN byte
        send_byte(8'hF0);
        send_byte(8'h00);
        send_byte(8'h56);
        send_nib(4'h0);
        reset = 1'b0;
        idle(1);
        chk_all_zero("reset_mid_len");
        idle(2);
        chk_all_zero("reset_mid_len_hold");
        reset = 1'b1;
        idle(3);
        pl[0] = 8'h5A;
        send_pkt(8'h00, 8'h56, 1);
        pl[0] = 8'hE1; pl[1] = 8'h2B;
        send_pkt(8'h80, 8'h47, 2);
        drain("after_reset");
        chk("no_overflow_after_reset", 32'(wo_overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
